// File: rtl/simple_fixed_pipe_pkg.sv
// Shared definitions for the SPU-Lite even-pipe simple fixed unit:
// opcode encoding, pipeline depth ceiling and slot-count helpers.
package defines_pkg;

    localparam int SF_MAX_LATENCY = 8;

    typedef enum logic [3:0] {
        IMMEDIATE_LOAD_HALFWORD       = 4'd0,
        IMMEDIATE_LOAD_HALFWORD_UPPER = 4'd1,
        IMMEDIATE_LOAD_WORD           = 4'd2,
        IMMEDIATE_LOAD_ADDRESS        = 4'd3,
        ADD_WORD                      = 4'd4,
        ADD_HALFWORD                  = 4'd5,
        SUBTRACT_FROM_WORD            = 4'd6,
        ADD_WORD_IMMEDIATE            = 4'd7,
        AND                           = 4'd8,
        OR                            = 4'd9,
        XOR                           = 4'd10
    } Opcodes;

    function automatic int word_slots(input int width);
        return width / 32;
    endfunction

    function automatic int half_slots(input int width);
        return width / 16;
    endfunction

endpackage

// File: rtl/simple_fixed_pipe_if.sv
// Issue / writeback / forwarding bundle of the simple fixed unit.
// The issue side (master) drives instructions; the unit (slave) returns results.
interface simple_fixed_pipe_if
    import defines_pkg::*;
#(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128,
    parameter int LATENCY     = 2
);

    logic                           in_valid;
    Opcodes                         opcode;
    logic [REG_ADDR_WD-1:0]         in_rt_addr;
    logic [REG_DATA_WD-1:0]         in_RA;
    logic [REG_DATA_WD-1:0]         in_RB;
    logic [9:0]                     in_I10;
    logic [15:0]                    in_I16;
    logic [17:0]                    in_I18;
    logic                           flush;

    logic                           out_valid;
    logic [REG_ADDR_WD-1:0]         out_rt_addr;
    logic [REG_DATA_WD-1:0]         out_RT;
    logic                           out_illegal;

    logic [LATENCY-1:0]             fwd_valid;
    logic [LATENCY*REG_ADDR_WD-1:0] fwd_addr;
    logic [LATENCY*REG_DATA_WD-1:0] fwd_data;

    modport master (
        output in_valid, opcode, in_rt_addr, in_RA, in_RB, in_I10, in_I16, in_I18, flush,
        input  out_valid, out_rt_addr, out_RT, out_illegal, fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  in_valid, opcode, in_rt_addr, in_RA, in_RB, in_I10, in_I16, in_I18, flush,
        output out_valid, out_rt_addr, out_RT, out_illegal, fwd_valid, fwd_addr, fwd_data
    );

endinterface

// File: rtl/simple_fixed_pipe_alu.sv
// Combinational datapath of the simple fixed unit: immediate loads,
// lane-wise add/subtract and bitwise logic with no carries between slots.
module simple_fixed_alu
    import defines_pkg::*;
#(
    parameter int REG_DATA_WD = 128
) (
    input  Opcodes                 opcode_i,
    input  logic [REG_DATA_WD-1:0] ra_i,
    input  logic [REG_DATA_WD-1:0] rb_i,
    input  logic [9:0]             i10_i,
    input  logic [15:0]            i16_i,
    input  logic [17:0]            i18_i,
    output logic [REG_DATA_WD-1:0] result_o,
    output logic                   illegal_o
);

    localparam int NW = word_slots(REG_DATA_WD);
    localparam int NH = half_slots(REG_DATA_WD);

    logic [31:0] i16_sext;
    logic [31:0] i10_sext;

    assign i16_sext = {{16{i16_i[15]}}, i16_i};
    assign i10_sext = {{22{i10_i[9]}}, i10_i};

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; without that, synthesis infers a latch.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            IMMEDIATE_LOAD_HALFWORD:
                for (int h = 0; h < NH; h++) result_o[16*h +: 16] = i16_i;
            IMMEDIATE_LOAD_HALFWORD_UPPER:
                for (int w = 0; w < NW; w++) result_o[32*w +: 32] = {i16_i, 16'h0000};
            IMMEDIATE_LOAD_WORD:
                for (int w = 0; w < NW; w++) result_o[32*w +: 32] = i16_sext;
            IMMEDIATE_LOAD_ADDRESS:
                for (int w = 0; w < NW; w++) result_o[32*w +: 32] = {14'b0, i18_i};
            ADD_WORD:
                for (int w = 0; w < NW; w++)
                    result_o[32*w +: 32] = ra_i[32*w +: 32] + rb_i[32*w +: 32];
            ADD_HALFWORD:
                for (int h = 0; h < NH; h++)
                    result_o[16*h +: 16] = ra_i[16*h +: 16] + rb_i[16*h +: 16];
            SUBTRACT_FROM_WORD:
                for (int w = 0; w < NW; w++)
                    result_o[32*w +: 32] = rb_i[32*w +: 32] - ra_i[32*w +: 32];
            ADD_WORD_IMMEDIATE:
                for (int w = 0; w < NW; w++)
                    result_o[32*w +: 32] = ra_i[32*w +: 32] + i10_sext;
            AND:     result_o = ra_i & rb_i;
            OR:      result_o = ra_i | rb_i;
            XOR:     result_o = ra_i ^ rb_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/simple_fixed_pipe.sv
// Simple fixed execution unit: ALU followed by LATENCY result stages, each
// exposed as a forwarding tap; flush turns every stage into a bubble.
module simple_fixed_pipe
    import defines_pkg::*;
#(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    simple_fixed_pipe_if.slave bus
);

    if (REG_DATA_WD % 32 != 0 || LATENCY < 1 || LATENCY > SF_MAX_LATENCY) begin : g_param_check
        $fatal(1, "simple_fixed_pipe: unsupported REG_DATA_WD=%0d / LATENCY=%0d",
               REG_DATA_WD, LATENCY);
    end

    logic [REG_DATA_WD-1:0] alu_result;
    logic                   alu_illegal;

    simple_fixed_alu #(.REG_DATA_WD(REG_DATA_WD)) u_alu (
        .opcode_i  (bus.opcode),
        .ra_i      (bus.in_RA),
        .rb_i      (bus.in_RB),
        .i10_i     (bus.in_I10),
        .i16_i     (bus.in_I16),
        .i18_i     (bus.in_I18),
        .result_o  (alu_result),
        .illegal_o (alu_illegal)
    );

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic                   src_valid, src_illegal;
        logic [REG_ADDR_WD-1:0] src_addr;
        logic [REG_DATA_WD-1:0] src_data;

        logic                   valid_d, valid_q;
        logic                   illegal_d, illegal_q;
        logic [REG_ADDR_WD-1:0] addr_d, addr_q;
        logic [REG_DATA_WD-1:0] data_d, data_q;

        if (s == 0) begin : g_src
            assign src_valid   = bus.in_valid;
            assign src_illegal = alu_illegal;
            assign src_addr    = bus.in_rt_addr;
            assign src_data    = alu_result;
        end else begin : g_src
            assign src_valid   = g_stage[s-1].valid_q;
            assign src_illegal = g_stage[s-1].illegal_q;
            assign src_addr    = g_stage[s-1].addr_q;
            assign src_data    = g_stage[s-1].data_q;
        end

        // Bubbles carry all-zero payload so forwarding consumers never see stale data.
        always_comb begin
            valid_d   = src_valid & ~bus.flush;
            illegal_d = valid_d & src_illegal;
            addr_d    = valid_d ? src_addr : '0;
            data_d    = valid_d ? src_data : '0;
        end

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value, regardless of block order.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
                addr_q    <= '0;
                data_q    <= '0;
            end else begin
                valid_q   <= valid_d;
                illegal_q <= illegal_d;
                addr_q    <= addr_d;
                data_q    <= data_d;
            end
        end

        assign bus.fwd_valid[s]                             = valid_q;
        assign bus.fwd_addr[s*REG_ADDR_WD +: REG_ADDR_WD]   = addr_q;
        assign bus.fwd_data[s*REG_DATA_WD +: REG_DATA_WD]   = data_q;
    end

    assign bus.out_valid   = g_stage[LATENCY-1].valid_q;
    assign bus.out_illegal = g_stage[LATENCY-1].illegal_q;
    assign bus.out_rt_addr = g_stage[LATENCY-1].addr_q;
    assign bus.out_RT      = g_stage[LATENCY-1].data_q;

endmodule

// File: tb/tb_simple_fixed_pipe.sv
// Scoreboard bench: one stimulus stream drives four differently parametrised
// units; each has its own expected-result queue and output monitor.
module tb_simple_fixed_pipe;
    import defines_pkg::*;

    localparam int N_DUT = 4;
    localparam longint unsigned M32 = 64'h1_0000_0000;
    localparam longint unsigned M16 = 64'h1_0000;

    function automatic int cfg_w(input int g);
        return (g == 3) ? 64 : 128;
    endfunction

    function automatic int cfg_l(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    typedef struct {
        logic [6:0]   addr;
        logic [127:0] data;
        logic         ill;
        int           issue;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, flush;
    Opcodes       opcode;
    logic [6:0]   rt;
    logic [127:0] ra, rb;
    logic [9:0]   i10;
    logic [15:0]  i16;
    logic [17:0]  i18;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic is_legal(input Opcodes op);
        return op inside {IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_HALFWORD_UPPER,
                          IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_ADDRESS, ADD_WORD,
                          ADD_HALFWORD, SUBTRACT_FROM_WORD, ADD_WORD_IMMEDIATE,
                          AND, OR, XOR};
    endfunction

    // Reference result for the full 128-bit vector; narrower units see its low bits.
    function automatic logic [127:0] model(input Opcodes op, input logic [127:0] a,
                                           input logic [127:0] b, input logic [9:0] im10,
                                           input logic [15:0] im16, input logic [17:0] im18);
        logic [127:0]    r;
        longint unsigned x, y, k;
        r = '0;
        case (op)
            IMMEDIATE_LOAD_HALFWORD:       r = {8{im16}};
            IMMEDIATE_LOAD_HALFWORD_UPPER: r = {4{im16, 16'h0000}};
            IMMEDIATE_LOAD_WORD: begin
                k = (im16 < 16'h8000) ? longint'(im16) : M32 - M16 + im16;
                r = {4{k[31:0]}};
            end
            IMMEDIATE_LOAD_ADDRESS: begin
                k = im18;
                r = {4{k[31:0]}};
            end
            ADD_WORD, SUBTRACT_FROM_WORD, ADD_WORD_IMMEDIATE: begin
                k = (im10 < 10'd512) ? longint'(im10) : M32 - 1024 + im10;
                for (int w = 0; w < 4; w++) begin
                    x = a[32*w +: 32];
                    y = b[32*w +: 32];
                    if (op == ADD_WORD)                r[32*w +: 32] = 32'((x + y) % M32);
                    else if (op == SUBTRACT_FROM_WORD) r[32*w +: 32] = 32'((M32 + y - x) % M32);
                    else                               r[32*w +: 32] = 32'((x + k) % M32);
                end
            end
            ADD_HALFWORD:
                for (int h = 0; h < 8; h++) begin
                    x = a[16*h +: 16];
                    y = b[16*h +: 16];
                    r[16*h +: 16] = 16'((x + y) % M16);
                end
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int W = cfg_w(g);
        localparam int L = cfg_l(g);

        simple_fixed_pipe_if #(.REG_ADDR_WD(7), .REG_DATA_WD(W), .LATENCY(L)) bus ();

        simple_fixed_pipe #(.REG_ADDR_WD(7), .REG_DATA_WD(W), .LATENCY(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.in_valid   = in_valid;
        assign bus.flush      = flush;
        assign bus.opcode     = opcode;
        assign bus.in_rt_addr = rt;
        assign bus.in_RA      = ra[W-1:0];
        assign bus.in_RB      = rb[W-1:0];
        assign bus.in_I10     = i10;
        assign bus.in_I16     = i16;
        assign bus.in_I18     = i18;

        exp_t q[$];
        int   cyc = 0;

        // Scoreboard capture: whatever the unit accepts at an edge is queued.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                q.delete();
            end else begin
                cyc++;
                if (flush) q.delete();
                else if (in_valid)
                    q.push_back('{addr: rt, data: model(opcode, ra, rb, i10, i16, i18),
                                  ill: !is_legal(opcode), issue: cyc});
            end
        end

        always @(negedge clk) begin : mon
            logic [L-1:0] exp_v;
            int           s;
            if (!rst) begin
                check($sformatf("d%0d rst out_valid", g), bus.out_valid, 0);
                check($sformatf("d%0d rst out_RT", g), bus.out_RT, 0);
                check($sformatf("d%0d rst out_rt_addr", g), bus.out_rt_addr, 0);
                check($sformatf("d%0d rst out_illegal", g), bus.out_illegal, 0);
                check($sformatf("d%0d rst fwd_valid", g), bus.fwd_valid, 0);
                check($sformatf("d%0d rst fwd_addr", g), bus.fwd_addr, 0);
                check($sformatf("d%0d rst fwd_data", g), 128'(bus.fwd_data), 0);
            end else begin
                exp_v = '0;
                foreach (q[i]) begin
                    s = cyc - q[i].issue;
                    if (s >= 0 && s < L) begin
                        exp_v[s] = 1'b1;
                        check($sformatf("d%0d fwd_addr[%0d]", g, s), bus.fwd_addr[s*7 +: 7], q[i].addr);
                        check($sformatf("d%0d fwd_data[%0d]", g, s), bus.fwd_data[s*W +: W],
                              q[i].data[W-1:0]);
                    end
                end
                check($sformatf("d%0d fwd_valid", g), bus.fwd_valid, exp_v);
                for (int k = 0; k < L; k++)
                    if (!exp_v[k]) begin
                        check($sformatf("d%0d bubble addr[%0d]", g, k), bus.fwd_addr[k*7 +: 7], 0);
                        check($sformatf("d%0d bubble data[%0d]", g, k), bus.fwd_data[k*W +: W], 0);
                    end
                if (q.size() > 0 && cyc - q[0].issue == L - 1) begin
                    check($sformatf("d%0d out_valid", g), bus.out_valid, 1);
                    check($sformatf("d%0d out_rt_addr", g), bus.out_rt_addr, q[0].addr);
                    check($sformatf("d%0d out_RT", g), bus.out_RT, q[0].data[W-1:0]);
                    check($sformatf("d%0d out_illegal", g), bus.out_illegal, q[0].ill);
                    void'(q.pop_front());
                end else begin
                    check($sformatf("d%0d idle out_valid", g), bus.out_valid, 0);
                    check($sformatf("d%0d idle out_RT", g), bus.out_RT, 0);
                    check($sformatf("d%0d idle out_rt_addr", g), bus.out_rt_addr, 0);
                    check($sformatf("d%0d idle out_illegal", g), bus.out_illegal, 0);
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic v, input logic f, input Opcodes op, input logic [6:0] a,
                         input logic [127:0] x, input logic [127:0] y, input logic [9:0] im10,
                         input logic [15:0] im16, input logic [17:0] im18);
        in_valid = v;
        flush    = f;
        opcode   = op;
        rt       = a;
        ra       = x;
        rb       = y;
        i10      = im10;
        i16      = im16;
        i18      = im18;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input logic v, input logic f, input logic [6:0] a);
        drive(v, f, Opcodes'(4'($urandom_range(0, 15))), a, rnd128(), rnd128(),
              10'($urandom), 16'($urandom), 18'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) rnd_cycle(1'b0, 1'b0, 7'($urandom));
    endtask

    task automatic issue(input Opcodes op, input logic [6:0] a, input logic [127:0] x,
                         input logic [127:0] y, input logic [9:0] im10, input logic [15:0] im16,
                         input logic [17:0] im18);
        drive(1'b1, 1'b0, op, a, x, y, im10, im16, im18);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (4) rnd_cycle(1'b1, 1'b0, 7'($urandom));
        rst = 1'b1;

        issue(IMMEDIATE_LOAD_HALFWORD, 7'd1, rnd128(), rnd128(), 10'd0, 16'h0017, 18'd0);
        idle(6);

        issue(ADD_WORD, 7'd2, {4{32'hFFFF_FFFF}}, {4{32'd1}}, 10'd0, 16'd0, 18'd0);
        issue(ADD_HALFWORD, 7'd3, {8{16'h8000}}, {8{16'h8000}}, 10'd0, 16'd0, 18'd0);
        issue(SUBTRACT_FROM_WORD, 7'd4, {4{32'd5}}, {4{32'd3}}, 10'd0, 16'd0, 18'd0);
        issue(IMMEDIATE_LOAD_WORD, 7'd5, rnd128(), rnd128(), 10'd0, 16'h8001, 18'd0);
        issue(IMMEDIATE_LOAD_ADDRESS, 7'd6, rnd128(), rnd128(), 10'd0, 16'd0, 18'h3FFFF);
        issue(ADD_WORD_IMMEDIATE, 7'd7, {4{32'd10}}, rnd128(), 10'h3FF, 16'd0, 18'd0);
        issue(IMMEDIATE_LOAD_HALFWORD_UPPER, 7'd8, rnd128(), rnd128(), 10'd0, 16'hBEEF, 18'd0);
        issue(Opcodes'(4'd14), 7'd9, rnd128(), rnd128(), 10'h155, 16'h1234, 18'h2AAAA);
        issue(AND, 7'd10, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        issue(OR, 7'd11, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        issue(XOR, 7'd12, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        idle(8);

        for (int i = 0; i < 10; i++)
            issue(Opcodes'(4'($urandom_range(0, 10))), 7'(i), rnd128(), rnd128(),
                  10'($urandom), 16'($urandom), 18'($urandom));
        idle(8);

        issue(ADD_WORD, 7'd20, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        drive(1'b1, 1'b1, XOR, 7'd21, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        issue(OR, 7'd22, rnd128(), rnd128(), 10'd0, 16'd0, 18'd0);
        idle(8);

        for (int i = 0; i < 4; i++) rnd_cycle(1'b1, 1'b0, 7'(30 + i));
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(8);

        for (int i = 0; i < 400; i++)
            rnd_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 7'($urandom));
        idle(10);

        check("d0 drained", 128'(g_dut[0].q.size()), 0);
        check("d1 drained", 128'(g_dut[1].q.size()), 0);
        check("d2 drained", 128'(g_dut[2].q.size()), 0);
        check("d3 drained", 128'(g_dut[3].q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_fixed_pipe.md
# simple_fixed_pipe

Pipelined, parametrised Simple Fixed execution unit for the SPU-Lite even pipe. It accepts one decoded instruction per cycle: opcode, operands, immediates and destination register address. It computes immediate-load, word/halfword add/subtract and logical results, then carries them through a configurable-depth result pipeline. Per-stage forwarding taps and a flush input connect it to the operand-forwarding network and to branch-mispredict recovery.

## Interface
- REG_ADDR_WD, 7, destination register address width
- REG_DATA_WD, 128, vector width; must be a multiple of 32
- LATENCY, 2, issue-to-writeback cycles; legal range 1..8
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-low (state clears while rst==0)
- in_valid  in  1  instruction issued this cycle
- opcode  in  Opcodes  decoded opcode, from the shared package
- in_rt_addr  in  REG_ADDR_WD  destination register
- in_RA, in_RB  in  REG_DATA_WD  source operands
- in_I10, in_I16, in_I18  in  10/16/18  immediates
- flush  in  1  kill all in-flight instructions
- out_valid  out  1  writeback valid
- out_rt_addr  out  REG_ADDR_WD  writeback register
- out_RT  out  REG_DATA_WD  writeback data
- out_illegal  out  1  writeback carries an unsupported opcode
- fwd_valid  out  LATENCY  per-stage valid; bit 0 is the youngest stage
- fwd_addr  out  LATENCY*REG_ADDR_WD  per-stage destination, flattened
- fwd_data  out  LATENCY*REG_DATA_WD  per-stage result, flattened

## Operation
- Word slot w = bits [32w+31:32w]; halfword slot h = bits [16h+15:16h]. All arithmetic wraps modulo the slot width; there are no carries between slots.
- IMMEDIATE_LOAD_HALFWORD: every halfword = I16.
- IMMEDIATE_LOAD_HALFWORD_UPPER: every word = {I16, 16'h0}.
- IMMEDIATE_LOAD_WORD: every word = sign-extended I16.
- IMMEDIATE_LOAD_ADDRESS: every word = zero-extended I18.
- ADD_WORD: RA+RB per word. ADD_HALFWORD: RA+RB per halfword.
- SUBTRACT_FROM_WORD: RB−RA per word.
- ADD_WORD_IMMEDIATE: RA + sign-extended I10, per word.
- AND, OR, XOR: bitwise on RA and RB.
- Any other opcode: result 0, and the illegal bit travels with the instruction.
- Stage 1 registers the ALU result. Stages 2..LATENCY shift it unchanged.
- Each stage holds {valid, illegal, rt_addr, data}. A stage holding no valid instruction is a bubble: addr, data and illegal all read 0.
- There is no back-pressure. The unit accepts an instruction every cycle and never stalls.
- flush=1: every stage, including the stage being loaded this cycle, becomes a bubble on the next edge. An instruction with in_valid=1 in the flush cycle is discarded.
- fwd_* always mirror the stage registers. The oldest stage (bit LATENCY−1) equals the out_* signals.

## Timing
- Latency: in_valid at cycle N gives out_valid at cycle N+LATENCY. LATENCY=1 means the result is registered once.
- Throughput is one per cycle. Back-to-back instructions emerge back-to-back, in order.
- Reset: while rst==0, every output is 0, asynchronously. After rst rises, the first instruction can be issued on the next edge.
- If reset is asserted mid-operation, all in-flight instructions are lost. Nothing emerges after release.
- Flush and reset are independent. Reset dominates.
- in_RA, in_RB, opcode and the immediates are sampled only at edges where in_valid=1. Otherwise they are ignored.

## Structure
- defines_pkg holds:
  - Opcodes entries for all eleven operations above
  - SF_MAX_LATENCY = 8
  - word/halfword slot-count helper functions
- Sub-module simple_fixed_alu: purely combinational; inputs are opcode, RA, RB and the immediates; outputs are result and illegal. It is parametrised by REG_DATA_WD.
- simple_fixed_pipe instantiates the ALU and a generate-loop array of LATENCY stage registers.
- Elaboration fails (assertion) if REG_DATA_WD%32≠0 or LATENCY is outside 1..8.

## Test plan
- Reset: hold rst=0 with random inputs and in_valid=1 → all outputs 0. Release, issue IMMEDIATE_LOAD_HALFWORD with I16=23 (16'h0017) → 2 cycles later out_valid=1 and out_RT = eight halfwords of 16'h0017.
- Wrap: ADD_WORD with RA words 32'hFFFF_FFFF and RB words 1 → all words 0. ADD_HALFWORD with 16'h8000+16'h8000 → 0. SUBTRACT_FROM_WORD with RA=5, RB=3 → 32'hFFFF_FFFE.
- Immediates: IMMEDIATE_LOAD_WORD with I16=16'h8001 → words 32'hFFFF_8001. IMMEDIATE_LOAD_ADDRESS with I18=18'h3FFFF → words 32'h0003_FFFF. ADD_WORD_IMMEDIATE with RA=10, I10=10'h3FF → 9.
- Streaming: 10 consecutive instructions with rt_addr 0..9 → 10 consecutive out_valid cycles with addresses 0..9 in order. fwd_valid=2'b11 is seen at steady state.
- Flush: issue 3 back-to-back instructions and assert flush in the 2nd issue cycle → only the 3rd emerges. fwd_valid reads 0 in the cycle after the flush.
- Illegal and params: an unsupported opcode → out_illegal=1 and out_RT=0. Rerun the streaming test with LATENCY=1 and LATENCY=5, and with REG_DATA_WD=64 → latency matches the parameter.
